// File: rtl/points_pkg.sv
// Shared widths, BCD digit type and digit helper for the score/lives tracker.
package points_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned LIFE_W  = 3;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Next value of a single BCD digit, wrapping 9 -> 0.
  function automatic bcd_digit_t bcd_next(input bcd_digit_t d);
    return (d == BCD_MAX) ? '0 : DIGIT_W'(d + 4'd1);
  endfunction

endpackage

// File: rtl/bcd_counter_2digit.sv
// Two-digit BCD counter 00..99 that saturates at 99; synchronous clear has priority over inc.
module bcd_counter_2digit
  import points_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output bcd_digit_t units,
  output bcd_digit_t tens
);

  logic at_max_c;

  assign at_max_c = (units == BCD_MAX) && (tens == BCD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      units <= '0;
      tens  <= '0;
    end else if (clr) begin
      units <= '0;
      tens  <= '0;
    end else if (inc && !at_max_c) begin
      units <= bcd_next(units);
      // Carry into tens only when units rolls over.
      if (units == BCD_MAX) begin
        tens <= bcd_next(tens);
      end
    end
  end

endmodule

// File: rtl/points_counter.sv
// Game score/lives tracker: rising edges of 'right' score BCD points, an idle window costs a life.
module points_counter
  import points_pkg::*;
#(
  parameter int unsigned LIFE_INIT      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              right,
  output logic [DIGIT_W-1:0] units_counter,
  output logic [DIGIT_W-1:0] tens_counter,
  output logic [LIFE_W-1:0]  life
);

  localparam int unsigned       TIMER_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LIFE_W-1:0]  LIFE_RESET = LIFE_W'(LIFE_INIT);

  logic               right_d;
  logic               game_over;
  logic [TIMER_W-1:0] timer;
  logic               point_c;
  logic               timeout_c;
  bcd_digit_t         units;
  bcd_digit_t         tens;

  assign point_c   = right & ~right_d & ~game_over;
  assign timeout_c = ~game_over & (timer == TIMER_LAST);

  // Previous sample of 'right'; clears to 0 so a level held through reset scores once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      right_d <= 1'b0;
    end else begin
      right_d <= right;
    end
  end

  // Idle timer: a point restarts the window, and the window also restarts on expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
    end else if (point_c || timeout_c) begin
      timer <= '0;
    end else if (!game_over) begin
      timer <= TIMER_W'(timer + TIMER_W'(1));
    end
  end

  // A point in the expiry cycle wins, so no life is lost then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      life      <= LIFE_RESET;
      game_over <= 1'b0;
    end else if (timeout_c && !point_c && (life != '0)) begin
      life <= LIFE_W'(life - LIFE_W'(1));
      if (life == LIFE_W'(1)) begin
        game_over <= 1'b1;
      end
    end
  end

  bcd_counter_2digit u_score (
    .clk   (clk),
    .rst_n (rst),
    .inc   (point_c),
    .clr   (1'b0),
    .units (units),
    .tens  (tens)
  );

  assign units_counter = units;
  assign tens_counter  = tens;

endmodule

// File: tb/tb_points_counter.sv
// Directed self-checking bench for points_counter with a short 8-cycle timeout window.
module tb_points_counter;

  logic       clk;
  logic       rst;
  logic       right;
  logic [3:0] units_counter;
  logic [3:0] tens_counter;
  logic [2:0] life;

  int pass_cnt;
  int total_cnt;

  points_counter #(
    .LIFE_INIT      (3),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .right         (right),
    .units_counter (units_counter),
    .tens_counter  (tens_counter),
    .life          (life)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b0;
    right = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      total_cnt++;
      if (units_counter !== 4'd0) $display("FAIL reset_units cyc%0d: got %0d want 0", i, units_counter);
      else pass_cnt++;
      total_cnt++;
      if (tens_counter !== 4'd0) $display("FAIL reset_tens cyc%0d: got %0d want 0", i, tens_counter);
      else pass_cnt++;
      total_cnt++;
      if (life !== 3'd3) $display("FAIL reset_life cyc%0d: got %0d want 3", i, life);
      else pass_cnt++;
    end
  endtask

  task automatic test_first_point;
    right = 1'b1;
    rst   = 1'b1;
    tick(1);
    total_cnt++;
    if (units_counter !== 4'd1) $display("FAIL first_point_units: got %0d want 1", units_counter);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (units_counter !== 4'd1) $display("FAIL held_right_units: got %0d want 1", units_counter);
    else pass_cnt++;
    total_cnt++;
    if (tens_counter !== 4'd0) $display("FAIL held_right_tens: got %0d want 0", tens_counter);
    else pass_cnt++;
  endtask

  task automatic test_toggles;
    int exp_score;
    exp_score = 1;
    for (int i = 0; i < 10; i++) begin
      right = 1'b0;
      tick(1);
      right = 1'b1;
      tick(1);
      exp_score++;
      total_cnt++;
      if (units_counter !== 4'(exp_score % 10))
        $display("FAIL toggle_units #%0d: got %0d want %0d", i, units_counter, exp_score % 10);
      else pass_cnt++;
      total_cnt++;
      if (tens_counter !== 4'(exp_score / 10))
        $display("FAIL toggle_tens #%0d: got %0d want %0d", i, tens_counter, exp_score / 10);
      else pass_cnt++;
    end
    total_cnt++;
    if (life !== 3'd3) $display("FAIL toggle_life: got %0d want 3", life);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    right = 1'b0;
    tick(7);
    total_cnt++;
    if (life !== 3'd3) $display("FAIL timeout_before: got %0d want 3", life);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (life !== 3'd2) $display("FAIL timeout_first: got %0d want 2", life);
    else pass_cnt++;
    tick(8);
    total_cnt++;
    if (life !== 3'd1) $display("FAIL timeout_second: got %0d want 1", life);
    else pass_cnt++;
    tick(7);
    total_cnt++;
    if (life !== 3'd1) $display("FAIL timeout_third_early: got %0d want 1", life);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (life !== 3'd0) $display("FAIL timeout_game_over: got %0d want 0", life);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      right = 1'b1;
      tick(1);
      right = 1'b0;
      tick(1);
    end
    tick(10);
    total_cnt++;
    if (units_counter !== 4'd1) $display("FAIL frozen_units: got %0d want 1", units_counter);
    else pass_cnt++;
    total_cnt++;
    if (tens_counter !== 4'd1) $display("FAIL frozen_tens: got %0d want 1", tens_counter);
    else pass_cnt++;
    total_cnt++;
    if (life !== 3'd0) $display("FAIL frozen_life: got %0d want 0", life);
    else pass_cnt++;
  endtask

  task automatic test_saturate;
    rst   = 1'b0;
    right = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    for (int i = 0; i < 99; i++) begin
      right = 1'b1;
      tick(1);
      right = 1'b0;
      tick(1);
    end
    total_cnt++;
    if (units_counter !== 4'd9 || tens_counter !== 4'd9)
      $display("FAIL preload_99: got %0d%0d want 99", tens_counter, units_counter);
    else pass_cnt++;
    total_cnt++;
    if (life !== 3'd3) $display("FAIL preload_life: got %0d want 3", life);
    else pass_cnt++;
    right = 1'b1;
    tick(1);
    total_cnt++;
    if (units_counter !== 4'd9 || tens_counter !== 4'd9)
      $display("FAIL saturate_99: got %0d%0d want 99", tens_counter, units_counter);
    else pass_cnt++;
    // Timer restarted by that point; land the next edge on the expiry cycle.
    right = 1'b0;
    tick(7);
    right = 1'b1;
    tick(1);
    total_cnt++;
    if (life !== 3'd3) $display("FAIL edge_on_timeout_life: got %0d want 3", life);
    else pass_cnt++;
    total_cnt++;
    if (units_counter !== 4'd9 || tens_counter !== 4'd9)
      $display("FAIL edge_on_timeout_score: got %0d%0d want 99", tens_counter, units_counter);
    else pass_cnt++;
    tick(7);
    total_cnt++;
    if (life !== 3'd3) $display("FAIL restart_window_early: got %0d want 3", life);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (life !== 3'd2) $display("FAIL restart_window_expiry: got %0d want 2", life);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    rst   = 1'b0;
    right = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    for (int i = 0; i < 37; i++) begin
      right = 1'b1;
      tick(1);
      right = 1'b0;
      tick(1);
    end
    tick(7);
    total_cnt++;
    if (units_counter !== 4'd7 || tens_counter !== 4'd3)
      $display("FAIL pre_reset_score: got %0d%0d want 37", tens_counter, units_counter);
    else pass_cnt++;
    total_cnt++;
    if (life !== 3'd2) $display("FAIL pre_reset_life: got %0d want 2", life);
    else pass_cnt++;
    right = 1'b1;
    rst   = 1'b0;
    #2;
    total_cnt++;
    if (units_counter !== 4'd0 || tens_counter !== 4'd0)
      $display("FAIL async_reset_score: got %0d%0d want 00", tens_counter, units_counter);
    else pass_cnt++;
    total_cnt++;
    if (life !== 3'd3) $display("FAIL async_reset_life: got %0d want 3", life);
    else pass_cnt++;
    tick(1);
    right = 1'b0;
    rst   = 1'b1;
    tick(2);
    total_cnt++;
    if (units_counter !== 4'd0 || tens_counter !== 4'd0)
      $display("FAIL no_pending_point: got %0d%0d want 00", tens_counter, units_counter);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b0;
    right     = 1'b0;
    test_reset();
    test_first_point();
    test_toggles();
    test_timeout();
    test_saturate();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
